dram_fifo_sync: RTL
===================

// Module: dram_fifo_sync
//
// PURPOSE
//   Single-clock FIFO built on a distributed-RAM array (synchronous write, asynchronous read).
//   Successor to the fixed 16-deep dual-port RAM used for TMDS channel-bonding buffers.
//   Adds the following parameters:
//     - depth as 2**ADDR_WIDTH
//     - full/empty/almost-full/almost-empty flags and occupancy
//     - overflow/underflow reporting
//     - selectable standard or first-word-fall-through (FWFT) read mode
//   Sits between the TMDS deserialiser and the channel-bonding/alignment logic. Also usable as
//   a generic small buffer in the DSI/HDMI datapaths.
//
// PARAMETERS
//   DATA_WIDTH   20  word width, bits (>=1)
//   ADDR_WIDTH   4   depth = 2**ADDR_WIDTH words (2..8)
//   AF_THRESH    12  ALMOST_FULL asserted when LEVEL >= AF_THRESH (1..depth)
//   AE_THRESH    2   ALMOST_EMPTY asserted when LEVEL <= AE_THRESH (0..depth-1)
//   FWFT         0   0 = standard read (registered output); 1 = first-word-fall-through
//
// PORTS
//   CLK           in   1               clock; all logic rising-edge
//   RST           in   1               synchronous reset, active-high
//   DATA_IN       in   DATA_WIDTH      write data
//   WRITE_EN      in   1               write request
//   READ_EN       in   1               read request (pop in FWFT mode)
//   DATA_OUT      out  DATA_WIDTH      read data
//   VALID         out  1               DATA_OUT holds a valid popped/head word
//   FULL          out  1               LEVEL == depth
//   EMPTY         out  1               LEVEL == 0
//   ALMOST_FULL   out  1               LEVEL >= AF_THRESH
//   ALMOST_EMPTY  out  1               LEVEL <= AE_THRESH
//   LEVEL         out  ADDR_WIDTH+1    current occupancy, 0..depth
//   OVERFLOW      out  1               1-cycle pulse: WRITE_EN while FULL
//   UNDERFLOW     out  1               1-cycle pulse: READ_EN while EMPTY
//
// BEHAVIOUR
//   Clock and reset
//   - One clock (CLK). RST is synchronous and active-high.
//   - On RST:
//       * write and read pointers = 0, LEVEL = 0
//       * EMPTY = 1, FULL = 0, ALMOST_EMPTY = 1, ALMOST_FULL = 0
//       * VALID = 0, DATA_OUT = 0, OVERFLOW = 0, UNDERFLOW = 0
//   - RAM contents are not cleared.
//   - RST mid-operation discards all contents. Any read or write in the reset cycle is ignored.
//
//   Storage and pointers
//   - Storage is a 2**ADDR_WIDTH x DATA_WIDTH array, written on the CLK edge at the write pointer.
//   - The read port is combinational from the read pointer.
//   - Pointers are ADDR_WIDTH bits and wrap modulo depth.
//   - LEVEL is an up/down counter of ADDR_WIDTH+1 bits.
//
//   Accept rules (evaluated on registered flags)
//   - Write accepted iff WRITE_EN && !FULL. No write-through when FULL, even with a
//     simultaneous read.
//   - Read accepted iff READ_EN && !EMPTY.
//   - Simultaneous accepted write and read: both pointers advance and LEVEL is unchanged.
//   - Rejected request: no state change; OVERFLOW or UNDERFLOW pulses high for the next cycle.
//
//   Flags
//   - All flags are registered and computed from next-LEVEL, so they are valid in the cycle
//     after the causing event.
//
//   FWFT = 0 (standard read)
//   - On an accepted read, DATA_OUT <= RAM[rd_ptr] and VALID <= 1 for exactly one cycle
//     (latency 1).
//   - Otherwise VALID <= 0 and DATA_OUT holds its previous value.
//
//   FWFT = 1 (first-word-fall-through)
//   - DATA_OUT = RAM[rd_ptr] combinationally and VALID = !EMPTY.
//   - READ_EN pops the head word.
//   - A word written into an empty FIFO appears on DATA_OUT (VALID = 1) in the cycle after
//     the write (latency 1).
//
//   Ordering
//   - Words leave in strict write order.
//   - No word is lost or duplicated across pointer wrap.
//
// TESTING
//   1. Reset, idle: flags EMPTY=1, ALMOST_EMPTY=1, others 0; LEVEL=0; VALID=0 for 10 cycles.
//   2. FWFT=0, depth 16: write 0x00001..0x00010 (16 words).
//        -> FULL=1 after the 16th; LEVEL=16; ALMOST_FULL set at LEVEL=12.
//      Then read 16.
//        -> DATA_OUT 0x00001..0x00010, each 1 cycle after READ_EN; EMPTY=1 at the end.
//   3. Full plus WRITE_EN=0xABCDE.
//        -> OVERFLOW pulses 1 cycle; LEVEL stays 16; 0xABCDE never read out.
//      Empty plus READ_EN.
//        -> UNDERFLOW pulses; VALID=0.
//   4. Half full (8 words), then 40 cycles of simultaneous write and read of an incrementing
//      count.
//        -> LEVEL stays 8; output sequence contiguous across pointer wrap.
//   5. FWFT=1: write 0x12345 to empty.
//        -> next cycle VALID=1, DATA_OUT=0x12345.
//      READ_EN for 1 cycle.
//        -> VALID=0, EMPTY=1 next cycle.
//   6. Write 5 words, assert RST for 1 cycle alongside WRITE_EN.
//        -> LEVEL=0, EMPTY=1.
//      Subsequent write/read of 0x0000F.
//        -> returns 0x0000F only.

Source files
------------

// File: rtl/dram_fifo_sync.sv
// Single-clock FIFO on a distributed-RAM array: synchronous write, asynchronous read.
// Latency: standard mode, DATA_OUT/VALID one cycle after an accepted read. FWFT mode,
//          a word written into an empty FIFO appears on DATA_OUT one cycle after the write.
// Backpressure: writes are dropped when FULL and reads when EMPTY. Each dropped request
//          raises OVERFLOW or UNDERFLOW for one cycle and changes no other state.
//
// Ports:
//   CLK, RST                 clock and synchronous active-high reset
//   DATA_IN, WRITE_EN        write data and write request
//   READ_EN                  read request (pops the head word in FWFT mode)
//   DATA_OUT, VALID          read data and its qualifier
//   FULL, EMPTY              LEVEL == depth, LEVEL == 0
//   ALMOST_FULL/EMPTY        LEVEL >= AF_THRESH, LEVEL <= AE_THRESH
//   LEVEL                    occupancy, 0..depth
//   OVERFLOW, UNDERFLOW      one-cycle pulses for rejected write/read requests
module dram_fifo_sync #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  WRITE_EN,
  input  logic                  READ_EN,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  VALID,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   LEVEL,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_L    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   AE_L    = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0]   LVL_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   level_q;
  logic [ADDR_WIDTH:0]   level_nxt;
  logic                  full_q;
  logic                  empty_q;
  logic                  af_q;
  logic                  ae_q;
  logic                  ovf_q;
  logic                  unf_q;
  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance uses the registered flags only, so a read in the same cycle never
  // opens room for a write into a full FIFO.
  assign wr_acc = WRITE_EN && !full_q;
  assign rd_acc = READ_EN  && !empty_q;

  always_comb begin
    level_nxt = level_q;
    if (wr_acc && !rd_acc) begin
      level_nxt = level_q + LVL_ONE;
    end else if (rd_acc && !wr_acc) begin
      level_nxt = level_q - LVL_ONE;
    end
  end

  // Storage is never reset; the reset cycle just suppresses the write.
  always_ff @(posedge CLK) begin
    if (!RST && wr_acc) begin
      mem[wr_ptr] <= DATA_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      level_q <= level_nxt;
      // Flags come from next-level so they agree with LEVEL in the same cycle.
      full_q  <= (level_nxt == DEPTH_L);
      empty_q <= (level_nxt == '0);
      af_q    <= (level_nxt >= AF_L);
      ae_q    <= (level_nxt <= AE_L);
      ovf_q   <= WRITE_EN && full_q;
      unf_q   <= READ_EN && empty_q;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word falls straight through from the RAM. It is forced to zero while
      // empty so stale RAM contents never show on DATA_OUT.
      assign DATA_OUT = empty_q ? '0 : mem[rd_ptr];
      assign VALID    = !empty_q;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] data_q;
      logic                  valid_q;

      always_ff @(posedge CLK) begin
        if (RST) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc;
          if (rd_acc) begin
            data_q <= mem[rd_ptr];
          end
        end
      end

      assign DATA_OUT = data_q;
      assign VALID    = valid_q;
    end
  endgenerate

  assign FULL         = full_q;
  assign EMPTY        = empty_q;
  assign ALMOST_FULL  = af_q;
  assign ALMOST_EMPTY = ae_q;
  assign LEVEL        = level_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = unf_q;

endmodule
